alien_step_ctrl: RTL
====================

# alien_step_ctrl

Parametrised formation-step generator for the Space Invaders alien block, the next generation of the fixed-rate move counter. It divides the enabled clock by a period chosen by a speed level, emits a one-cycle step pulse, and tracks the formation's horizontal offset and direction. At each screen edge it emits a drop pulse instead of a horizontal move. The alien renderer and the collision logic consume its outputs.

## Interface
- CNT_W, 24: width of the period counter.
- BASE_PERIOD, 5_000_000: enabled cycles per step at Level 0.
- MIN_PERIOD, 500_000: floor on the effective period; must be ≥ 1.
- LVL_W, 3: width of Level.
- X_W, 10: width of X_off.
- X_MIN, 0: left bound of X_off.
- X_MAX, 160: right bound of X_off.
- X_START, 0: reset value of X_off; must lie in [X_MIN, X_MAX].
- STEP_X, 4: horizontal pixels moved per step.
- CLK  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  reset, synchronous and active-low.
- EN  in  1  count qualifier; the period counter advances only when EN=1.
- Pause  in  1  freeze; when 1, the counter and all state hold.
- Level  in  LVL_W  speed level; a higher value gives a faster step rate.
- M1  out  1  step pulse, high for exactly one cycle per step.
- Drop  out  1  one-cycle pulse on an edge step (formation moves down).
- Dir  out  1  0 = moving right, 1 = moving left.
- X_off  out  X_W  current horizontal offset of the formation.
- Step_cnt  out  8  count of steps taken, wrapping at 255.

## Operation
- Effective period: P = max(BASE_PERIOD >> Level, MIN_PERIOD).
  - P is recomputed combinationally every cycle.
  - Level may change at any time.
- Active cycle: a cycle with Rst=1, EN=1 and Pause=0.
  - On each active cycle, if cnt ≥ P−1: cnt←0 and a step occurs. Otherwise cnt←cnt+1.
  - The ≥ comparison means that when Level rises while cnt is already past the new P−1, the step occurs on the next active cycle.
- Step when Dir=0:
  - If X_off+STEP_X > X_MAX: edge step. Dir←1, Drop←1, X_off is unchanged.
  - Otherwise: X_off←X_off+STEP_X.
- Step when Dir=1:
  - If X_off < X_MIN+STEP_X: edge step. Dir←0, Drop←1, X_off is unchanged.
  - Otherwise: X_off←X_off−STEP_X.
  - Compute the left-edge test without underflow, i.e. do not form X_off−STEP_X before comparing.
- Every step, edge steps included: M1←1 and Step_cnt←Step_cnt+1 (mod 256).
- M1 and Drop are 0 on every cycle that is not a step.
- Pause=1 with EN=1: nothing advances. An in-progress count is preserved.
- Rst=0 is sampled on the edge and takes priority over EN and Pause. On that edge:
  - cnt←0, M1←0, Drop←0, Dir←0, X_off←X_START, Step_cnt←0.
  - Asserting reset mid-count discards the partial count. The first step after release needs a full P active cycles.
- Level, EN and Pause need no synchronisation; they come from the same CLK domain.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- M1, Drop, Dir, X_off and Step_cnt all update on the same rising edge: the edge that samples the terminal active cycle.
- Latency: after reset release with EN held at 1, the first M1 is high in the cycle following the P-th active edge.
- Steady state at constant Level with EN=1: M1 pulses every P cycles, each pulse one cycle wide.
- With EN asserted one cycle in k, the M1 spacing is P·k cycles.
- Reset values of all outputs: M1=0, Drop=0, Dir=0, X_off=X_START, Step_cnt=0.
- Drop is never high without M1 in the same cycle.

## Test plan
Parameters for all scenarios: BASE_PERIOD=16, MIN_PERIOD=2, LVL_W=3, X_W=8, X_MIN=0, X_MAX=12, X_START=0, STEP_X=4.
- Reset, then EN=1, Level=0 → M1 one cycle wide every 16 cycles; X_off goes 0→4→8→12; Step_cnt goes 1,2,3.
- Continue from X_off=12 with Dir=0 → the next step gives Drop=1 with M1=1, Dir=1, X_off stays 12. The following steps give 8,4,0, then a Drop at 0 with Dir→0.
- Level=2 → M1 every 4 cycles. Level=5 (16>>5=0, clamped) → M1 every 2 cycles.
- Level=0 with cnt=10, then switch to Level=2 → M1 on the next active cycle; afterwards every 4 cycles.
- EN toggling 1,0,1,0 at Level=0 → M1 every 32 cycles. Pause=1 for 7 cycles mid-count → the next M1 is delayed by exactly 7 cycles.
- Rst=0 for 1 cycle at cnt=9, X_off=8 → next edge: all outputs at reset values; the first M1 arrives 16 active cycles after release; Step_cnt wraps 255→0 on the 256th step.

Source files
------------

// File: rtl/alien_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alien_step_ctrl
// Brief    : Formation-step generator for the alien block: level-scaled step
//            period, horizontal sweep with edge drop, step counter.
// Revision : 1.0 - initial release
// ============================================================================
module alien_step_ctrl #(
   parameter int CNT_W       = 24,
   parameter int BASE_PERIOD = 5_000_000,
   parameter int MIN_PERIOD  = 500_000,
   parameter int LVL_W       = 3,
   parameter int X_W         = 10,
   parameter int X_MIN       = 0,
   parameter int X_MAX       = 160,
   parameter int X_START     = 0,
   parameter int STEP_X      = 4
) (
   input  logic             CLK,
   input  logic             Rst,
   input  logic             EN,
   input  logic             Pause,
   input  logic [LVL_W-1:0] Level,
   output logic             M1,
   output logic             Drop,
   output logic             Dir,
   output logic [X_W-1:0]   X_off,
   output logic [7:0]       Step_cnt
);

   localparam logic [CNT_W-1:0] c_base   = CNT_W'(BASE_PERIOD);
   localparam logic [CNT_W-1:0] c_min    = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);
   localparam logic [X_W:0]     c_step_w = (X_W+1)'(STEP_X);
   localparam logic [X_W:0]     c_xmax_w = (X_W+1)'(X_MAX);
   localparam logic [X_W:0]     c_left_w = (X_W+1)'(X_MIN + STEP_X);
   localparam logic [X_W-1:0]   c_step   = X_W'(STEP_X);
   localparam logic [X_W-1:0]   c_xstart = X_W'(X_START);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_shift;
   logic [CNT_W-1:0] w_last;
   logic [X_W:0]     w_xext;
   logic             w_active;
   logic             w_step;
   logic             w_redge;
   logic             w_ledge;
   logic             w_edge;

   // Edge tests use one extra bit so neither the add nor the left bound can wrap.
   always_comb begin
      w_shift  = c_base >> Level;
      w_last   = ((w_shift < c_min) ? c_min : w_shift) - c_one;
      w_active = EN && !Pause;
      w_step   = w_active && (r_cnt >= w_last);
      w_xext   = {1'b0, X_off};
      w_redge  = (w_xext + c_step_w) > c_xmax_w;
      w_ledge  = w_xext < c_left_w;
      w_edge   = Dir ? w_ledge : w_redge;
   end

   always_ff @(posedge CLK) begin
      if (!Rst) begin
         r_cnt    <= '0;
         M1       <= 1'b0;
         Drop     <= 1'b0;
         Dir      <= 1'b0;
         X_off    <= c_xstart;
         Step_cnt <= 8'd0;
      end else begin
         M1   <= 1'b0;
         Drop <= 1'b0;
         if (w_step) begin
            r_cnt    <= '0;
            M1       <= 1'b1;
            Step_cnt <= Step_cnt + 8'd1;
            if (w_edge) begin
               Drop <= 1'b1;
               Dir  <= !Dir;
            end else if (Dir) begin
               X_off <= X_off - c_step;
            end else begin
               X_off <= X_off + c_step;
            end
         end else if (w_active) begin
            r_cnt <= r_cnt + c_one;
         end
      end
   end

endmodule
`default_nettype wire
